mdu_hilo_unit: RTL and testbench

//  Parametrised multiply/divide unit that owns the HI/LO register pair for the alpha pipeline.

---
 rtl/mdu_hilo_unit.sv | 194 +++++++++++++++++++
 tb/tb_mdu_hilo_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo_unit.sv
// Multiply/divide unit owning the HI/LO pair: fixed-latency multiply, iterative divide.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate into {HI,LO}.
module mdu_hilo_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               op_valid_i,
  input  logic [3:0]         op_i,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] hilo_o
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
`ifdef MDU_MADD_EN
  logic             r_acc;
  logic             r_sub;
`endif

  logic w_is_mul;
  logic w_is_div;
  logic w_is_mt;
  logic w_accept;
  logic w_commit;

  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_is_mt  = 1'b0;
    case (op_i)
      4'd0, 4'd1: w_is_mul = 1'b1;
      4'd2, 4'd3: w_is_div = 1'b1;
      4'd4, 4'd5: w_is_mt  = 1'b1;
`ifdef MDU_MADD_EN
      4'd8, 4'd9, 4'd10, 4'd11: w_is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  assign w_accept = op_valid_i & ~flush_i & ~rst
                  & (r_state == S_IDLE)
                  & (w_is_mul | w_is_div | w_is_mt);

  assign w_commit = ((r_state == S_MUL) && (r_cnt == MUL_LAST))
                  | ((r_state == S_DIV) && (r_cnt == DIV_LAST));

  // Busy drops in the commit cycle so the pipeline can issue into IDLE next cycle
  assign busy_o = ~flush_i & ~rst
                & (((r_state != S_IDLE) & ~w_commit)
                   | (w_accept & (w_is_mul | w_is_div)));
  assign done_o = w_commit & ~flush_i & ~rst;
  assign hilo_o = {r_hi, r_lo};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul) w_state_nxt = S_MUL;
        if (w_accept && w_is_div) w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (flush_i || w_commit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  logic [2*WIDTH-1:0] w_ma;
  logic [2*WIDTH-1:0] w_mb;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_res;

  assign w_ma = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a}
                         : {{WIDTH{1'b0}}, r_a};
  assign w_mb = r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b}
                         : {{WIDTH{1'b0}}, r_b};
  assign w_prod = w_ma * w_mb;

`ifdef MDU_MADD_EN
  assign w_mul_res = !r_acc ? w_prod
                   : r_sub  ? ({r_hi, r_lo} - w_prod)
                            : ({r_hi, r_lo} + w_prod);
`else
  assign w_mul_res = w_prod;
`endif

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_a_neg;
  logic             w_b_neg;

  // Restoring step: remainder stays below the divisor, so the borrow bit is the sign
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[WIDTH];
  assign w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;
  assign w_a_neg = ~op_i[0] & src_a[WIDTH-1];
  assign w_b_neg = ~op_i[0] & src_b[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`ifdef MDU_MADD_EN
      r_acc    <= 1'b0;
      r_sub    <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_signed <= ~op_i[0];
        if (w_is_mt && !op_i[0]) r_hi <= src_a;
        if (w_is_mt &&  op_i[0]) r_lo <= src_a;
        if (w_is_mul) begin
          r_a <= src_a;
          r_b <= src_b;
`ifdef MDU_MADD_EN
          r_acc <= op_i[3];
          r_sub <= op_i[1];
`endif
        end
        if (w_is_div) begin
          r_quo   <= w_a_neg ? (~src_a + 1'b1) : src_a;
          r_dvs   <= w_b_neg ? (~src_b + 1'b1) : src_b;
          r_rem   <= '0;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
        end
      end else if (flush_i) begin
        r_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == S_DIV && !w_commit) begin
        r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
      end

      if (done_o) begin
        if (r_state == S_MUL) {r_hi, r_lo} <= w_mul_res;
        else                  {r_hi, r_lo} <= {w_r_fix, w_q_fix};
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Directed vector bench for mdu_hilo_unit (WIDTH=32, MUL_LATENCY=4).
// Accumulate expectations follow MDU_MADD_EN.
module tb_mdu_hilo_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        op_valid_i;
  logic [3:0]  op_i;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy_o;
  logic        done_o;
  logic [63:0] hilo_o;

  mdu_hilo_unit #(
    .WIDTH(32),
    .MUL_LATENCY(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush_i(flush_i),
    .op_valid_i(op_valid_i),
    .op_i(op_i),
    .src_a(src_a),
    .src_b(src_b),
    .busy_o(busy_o),
    .done_o(done_o),
    .hilo_o(hilo_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    int          nbusy;
  } vec_t;

  vec_t        tv[14];
  vec_t        extra;
  logic [63:0] prev;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int nb;
    int dc;
    int bound;
    bound = (v.lat < 0) ? 3 : 40;
    op_valid_i = 1'b1;
    op_i  = v.op;
    src_a = v.a;
    src_b = v.b;
    #1;
    nb = busy_o ? 1 : 0;
    dc = -1;
    for (int k = 1; k <= bound && dc < 0; k++) begin
      @(posedge clk);
      #1;
      op_valid_i = 1'b0;
      #1;
      if (busy_o) nb++;
      if (done_o) begin
        dc = k;
        chk($sformatf("v%0d_nobypass", idx), hilo_o, prev);
      end
    end
    if (dc >= 0) step();
    chk($sformatf("v%0d_latency", idx), 64'(dc), 64'(v.lat));
    chk($sformatf("v%0d_busy", idx), 64'(nb), 64'(v.nbusy));
    chk($sformatf("v%0d_hilo", idx), hilo_o, v.exp);
    prev = v.exp;
  endtask

  initial begin
    int seen_done;
    int dc;

    tv[0]  = '{4'd0, 32'hFFFF_FFFE, 32'd3,
               64'hFFFF_FFFF_FFFF_FFFA, 4, 4};
    tv[1]  = '{4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, 4, 4};
    tv[2]  = '{4'd0, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000, 4, 4};
    tv[3]  = '{4'd0, 32'd7, 32'hFFFF_FFFB,
               64'hFFFF_FFFF_FFFF_FFDD, 4, 4};
    tv[4]  = '{4'd3, 32'd100, 32'd7,
               64'h0000_0002_0000_000E, 33, 33};
    tv[5]  = '{4'd2, 32'hFFFF_FFF9, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 33, 33};
    tv[6]  = '{4'd2, 32'h8000_0000, 32'hFFFF_FFFF,
               64'h0000_0000_8000_0000, 33, 33};
    tv[7]  = '{4'd3, 32'd5, 32'd0,
               64'h0000_0005_FFFF_FFFF, 33, 33};
    tv[8]  = '{4'd2, 32'd7, 32'hFFFF_FFFE,
               64'h0000_0001_FFFF_FFFD, 33, 33};
    tv[9]  = '{4'd6, 32'hDEAD, 32'd1,
               64'h0000_0001_FFFF_FFFD, -1, 0};
    tv[10] = '{4'd4, 32'hABCD, 32'd0,
               64'h0000_ABCD_FFFF_FFFD, -1, 0};
    tv[11] = '{4'd5, 32'd0, 32'd0,
               64'h0000_ABCD_0000_0000, -1, 0};
    tv[12] = '{4'd4, 32'd1, 32'd0,
               64'h0000_0001_0000_0000, -1, 0};
`ifdef MDU_MADD_EN
    tv[13] = '{4'd11, 32'd1, 32'd1,
               64'h0000_0000_FFFF_FFFF, 4, 4};
`else
    tv[13] = '{4'd11, 32'd1, 32'd1,
               64'h0000_0001_0000_0000, -1, 0};
`endif

    rst        = 1'b1;
    flush_i    = 1'b0;
    op_valid_i = 1'b1;
    op_i       = 4'd4;
    src_a      = 32'h55;
    src_b      = 32'd0;
    step();
    chk("rst_hilo", hilo_o, 64'd0);
    op_i = 4'd0;
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    step();
    chk("rst_hilo2", hilo_o, 64'd0);
    rst        = 1'b0;
    op_valid_i = 1'b0;
    #1;
    prev = 64'd0;

    for (int i = 0; i < 14; i++) run_vec(tv[i], i);

    step();
    op_valid_i = 1'b1;
    op_i  = 4'd4;
    src_a = 32'h1234;
    #1;
    chk("mthi_busy", 64'(busy_o), 64'd0);
    step();
    op_i  = 4'd5;
    src_a = 32'h5678;
    #1;
    chk("mtlo_busy", 64'(busy_o), 64'd0);
    chk("mtlo_done", 64'(done_o), 64'd0);
    step();
    op_valid_i = 1'b0;
    #1;
    chk("mt_b2b_hilo", hilo_o, 64'h0000_1234_0000_5678);

    step();
    seen_done  = 0;
    op_valid_i = 1'b1;
    op_i  = 4'd3;
    src_a = 32'd100;
    src_b = 32'd7;
    #1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      op_valid_i = 1'b0;
      flush_i    = (k == 10);
      if (k == 12) begin
        op_valid_i = 1'b1;
        op_i  = 4'd1;
        src_a = 32'd3;
        src_b = 32'd5;
      end
      #1;
      if (done_o) seen_done++;
      if (k == 10) chk("flush_busy", 64'(busy_o), 64'd0);
      if (k == 11) begin
        chk("flush_idle_busy", 64'(busy_o), 64'd0);
        chk("flush_hilo", hilo_o, 64'h0000_1234_0000_5678);
      end
      if (k == 12) chk("reissue_busy", 64'(busy_o), 64'd1);
    end
    chk("flush_nodone", 64'(seen_done), 64'd0);
    dc = -1;
    for (int k = 1; k <= 10 && dc < 0; k++) begin
      step();
      op_valid_i = 1'b0;
      #1;
      if (done_o) dc = k;
    end
    chk("reissue_latency", 64'(dc), 64'd4);
    step();
    chk("reissue_hilo", hilo_o, 64'h0000_0000_0000_000F);

    op_valid_i = 1'b1;
    op_i  = 4'd0;
    src_a = 32'd2;
    src_b = 32'd3;
    #1;
    for (int k = 1; k <= 5; k++) begin
      step();
      op_valid_i = 1'b0;
      flush_i    = (k == 4);
      #1;
      if (k == 4) chk("commit_flush_done", 64'(done_o), 64'd0);
    end
    chk("commit_flush_hilo", hilo_o, 64'h0000_0000_0000_000F);
    chk("commit_flush_busy", 64'(busy_o), 64'd0);
    prev  = 64'h0000_0000_0000_000F;
    extra = '{4'd0, 32'd2, 32'd3, 64'h0000_0000_0000_0006, 4, 4};
    run_vec(extra, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
